// File: rtl/in_service_acknowledge_8259a.sv
// 8259A in-service / acknowledge block: priority resolution, INT generation,
// two-pulse 8086 INTA# sequence, ISR bookkeeping and vector delivery.
module in_service_acknowledge_8259a #(
    parameter logic [2:0] SPURIOUS_ID = 3'd7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       interrupt_acknowledge_n,
    input  logic       auto_eoi_config,
    input  logic       rotate_on_auto_eoi,
    input  logic       non_specific_eoi,
    input  logic [7:0] specific_eoi,
    input  logic [4:0] vector_base,
    output logic       interrupt_to_cpu,
    output logic [7:0] clear_interrupt_request,
    output logic       freeze,
    output logic [7:0] in_service_register,
    output logic [7:0] vector_out,
    output logic       vector_out_enable
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ACK1      = 2'd1;
    localparam logic [1:0] ACK2_WAIT = 2'd2;
    localparam logic [1:0] ACK2      = 2'd3;

    logic [1:0] r_state;
    logic [2:0] r_lowest_priority;
    logic       r_inta_prev;
    logic [2:0] r_level;
    logic       r_spurious;
    logic       r_int;
    logic [7:0] r_clear;
    logic       r_freeze;
    logic [7:0] r_isr;
    logic [7:0] r_vector;
    logic       r_vector_en;

    logic       w_fall;
    logic       w_rise;
    logic [7:0] w_candidate;
    logic       w_cand_valid;
    logic [2:0] w_cand_rank;
    logic       w_isr_valid;
    logic [2:0] w_isr_rank;
    logic [2:0] w_winner;
    logic [2:0] w_isr_top;
    logic       w_eligible;
    logic [7:0] w_isr_set;
    logic [7:0] w_isr_clr;
    logic [7:0] w_isr_next;

    assign w_fall = r_inta_prev & ~interrupt_acknowledge_n;
    assign w_rise = ~r_inta_prev & interrupt_acknowledge_n;

    // Rank 0 is the highest-priority level, i.e. lowest_priority + 1 (mod 8).
    always_comb begin
        logic [2:0] idx;
        w_candidate  = interrupt_request_register & ~interrupt_mask;
        w_cand_valid = 1'b0;
        w_cand_rank  = 3'd0;
        w_isr_valid  = 1'b0;
        w_isr_rank   = 3'd0;
        idx          = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = 3'(r_lowest_priority + 3'd1 + 3'(k));
            if (w_candidate[idx]) begin
                w_cand_valid = 1'b1;
                w_cand_rank  = 3'(k);
            end
            if (r_isr[idx]) begin
                w_isr_valid = 1'b1;
                w_isr_rank  = 3'(k);
            end
        end
        w_winner   = 3'(r_lowest_priority + 3'd1 + w_cand_rank);
        w_isr_top  = 3'(r_lowest_priority + 3'd1 + w_isr_rank);
        // Fully nested: only strictly higher priority than the top ISR bit
        w_eligible = w_cand_valid && (!w_isr_valid || (w_cand_rank < w_isr_rank));
    end

    // ISR next state: clears from EOIs / auto-EOI, set on first INTA wins.
    always_comb begin
        w_isr_set = 8'h00;
        w_isr_clr = specific_eoi;
        if (r_state == IDLE && w_fall && w_eligible) begin
            w_isr_set[w_winner] = 1'b1;
        end
        if (non_specific_eoi && w_isr_valid) begin
            w_isr_clr[w_isr_top] = 1'b1;
        end
        if (r_state == ACK2 && w_rise && auto_eoi_config && !r_spurious) begin
            w_isr_clr[r_level] = 1'b1;
        end
        w_isr_next = (r_isr & ~w_isr_clr) | w_isr_set;
    end

    // Acknowledge FSM, INT, freeze, clear pulse and vector registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state           <= IDLE;
            r_lowest_priority <= 3'd7;
            r_inta_prev       <= 1'b1;
            r_level           <= 3'd0;
            r_spurious        <= 1'b0;
            r_int             <= 1'b0;
            r_clear           <= 8'h00;
            r_freeze          <= 1'b0;
            r_isr             <= 8'h00;
            r_vector          <= 8'h00;
            r_vector_en       <= 1'b0;
        end else begin
            r_inta_prev <= interrupt_acknowledge_n;
            r_isr       <= w_isr_next;
            r_clear     <= w_isr_set;
            r_int       <= (r_state == IDLE && !w_fall) ? w_eligible : 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_freeze   <= 1'b1;
                        r_state    <= ACK1;
                        r_spurious <= ~w_eligible;
                        r_level    <= w_eligible ? w_winner : SPURIOUS_ID;
                    end
                end
                ACK1: begin
                    if (w_rise) begin
                        r_state <= ACK2_WAIT;
                    end
                end
                ACK2_WAIT: begin
                    if (w_fall) begin
                        r_vector    <= {vector_base, r_level};
                        r_vector_en <= 1'b1;
                        r_state     <= ACK2;
                    end
                end
                default: begin
                    if (w_rise) begin
                        r_vector_en <= 1'b0;
                        r_freeze    <= 1'b0;
                        r_state     <= IDLE;
                        if (auto_eoi_config && !r_spurious && rotate_on_auto_eoi) begin
                            r_lowest_priority <= r_level;
                        end
                    end
                end
            endcase
        end
    end

    assign interrupt_to_cpu        = r_int;
    assign clear_interrupt_request = r_clear;
    assign freeze                  = r_freeze;
    assign in_service_register     = r_isr;
    assign vector_out              = r_vector;
    assign vector_out_enable       = r_vector_en;

endmodule
